// File: rtl/hazard_fwd_pkg.sv
// Shared types for the decode-stage hazard/forwarding controller: mux select
// codes, the stall FSM state and the shadow-pipeline slot record.
package hazard_fwd_pkg;

  localparam int SLOT_REG_W = 5;

  localparam logic [1:0] FW_REG = 2'b00;
  localparam logic [1:0] FW_MEM = 2'b01;
  localparam logic [1:0] FW_ALU = 2'b10;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  typedef struct packed {
    logic                  v;
    logic [SLOT_REG_W-1:0] rd;
    logic                  wr;
    logic                  ld;
    logic                  fl;
  } shadow_slot_t;

endpackage

// File: rtl/hazard_forward_ctrl_fwd_sel_unit.sv
// One operand's forwarding-mux select, derived from the EX and MEM shadow slots.
// A load in EX cannot forward yet; that case is covered by the load-use stall.
module fwd_sel_unit
  import hazard_fwd_pkg::*;
#(
  parameter int REG_W    = SLOT_REG_W,
  parameter int ZERO_REG = 31
) (
  input  logic [REG_W-1:0] src,
  input  logic             use_src,
  input  shadow_slot_t     ex_slot,
  input  shadow_slot_t     mem_slot,
  output logic [1:0]       sel
);

  logic unused_slot_bits;
  assign unused_slot_bits = ^{ex_slot.fl, mem_slot.ld, mem_slot.fl};

  always_comb begin
    sel = FW_REG;
    if (use_src && (src != REG_W'(ZERO_REG))) begin
      if (ex_slot.v && ex_slot.wr && !ex_slot.ld && (ex_slot.rd == src)) begin
        sel = FW_ALU;
      end else if (mem_slot.v && mem_slot.wr && (mem_slot.rd == src)) begin
        sel = FW_MEM;
      end
    end
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Decode-stage hazard detection, forwarding selects, stall FSM and IF/ID flush.
// Optional saturating stall/flush counters are enabled by HAZARD_FWD_PERF_CNT_EN.
module hazard_forward_ctrl
  import hazard_fwd_pkg::*;
#(
  parameter int REG_W    = SLOT_REG_W,
  parameter int ZERO_REG = 31,
  parameter int PERF_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dec_valid,
  input  logic [REG_W-1:0] dec_rs1,
  input  logic [REG_W-1:0] dec_rs2,
  input  logic             dec_use_rs1,
  input  logic             dec_use_rs2,
  input  logic [REG_W-1:0] dec_rd,
  input  logic             dec_regwrite,
  input  logic             dec_memread,
  input  logic             dec_setflags,
  input  logic             dec_is_bcond,
  input  logic             dec_br_taken,
  output logic [1:0]       fw1_sel,
  output logic [1:0]       fw2_sel,
  output logic             stall,
  output logic             bubble_ex,
  output logic             flush_ifid
`ifdef HAZARD_FWD_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt
`endif
);

  shadow_slot_t ex_slot;
  shadow_slot_t mem_slot;
  state_t       state;
  state_t       next_state;
  logic         load_use;
  logic         flag_hazard;
  logic         hazard;

  // The MEM slot only needs v/rd/wr; ld and fl are kept at zero there.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_slot  <= '0;
      mem_slot <= '0;
      state    <= RUN;
    end else begin
      mem_slot <= '{v: ex_slot.v, rd: ex_slot.rd, wr: ex_slot.wr, ld: 1'b0, fl: 1'b0};
      ex_slot  <= '{v: dec_valid & ~stall, rd: dec_rd, wr: dec_regwrite,
                    ld: dec_memread, fl: dec_setflags};
      state    <= next_state;
    end
  end

  fwd_sel_unit #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_fwd1 (
    .src     (dec_rs1),
    .use_src (dec_use_rs1),
    .ex_slot (ex_slot),
    .mem_slot(mem_slot),
    .sel     (fw1_sel)
  );

  fwd_sel_unit #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_fwd2 (
    .src     (dec_rs2),
    .use_src (dec_use_rs2),
    .ex_slot (ex_slot),
    .mem_slot(mem_slot),
    .sel     (fw2_sel)
  );

  always_comb begin
    load_use    = ex_slot.v && ex_slot.ld && ex_slot.wr
                  && (ex_slot.rd != REG_W'(ZERO_REG))
                  && ((dec_use_rs1 && (dec_rs1 == ex_slot.rd))
                      || (dec_use_rs2 && (dec_rs2 == ex_slot.rd)));
    flag_hazard = dec_is_bcond && ex_slot.v && ex_slot.fl;
    hazard      = load_use || flag_hazard;
  end

  // A new hazard while already in HOLD re-stalls and stays in HOLD.
  always_comb begin
    next_state = state;
    stall      = hazard && dec_valid;
    bubble_ex  = hazard && dec_valid;
    case (state)
      RUN:     next_state = stall ? HOLD : RUN;
      HOLD:    next_state = stall ? HOLD : RUN;
      default: next_state = RUN;
    endcase
  end

  assign flush_ifid = reset && dec_valid && dec_br_taken && !stall;

`ifdef HAZARD_FWD_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (flush_ifid && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end
`else
  localparam int UNUSED_PERF_W = PERF_W;
`endif

endmodule

// File: doc/hazard_forward_ctrl.md
Name: hazard_forward_ctrl

Overview:
Per-cycle sequencer for the register/decode stage of the pipelined CPU. It tracks in-flight destination registers in a private shadow pipeline covering the EX and MEM slots, drives the two decode-stage forwarding mux selects, and detects load-use and flag hazards. It stalls the front end with a small FSM and flushes IF/ID on taken accelerated branches.

Parameters:
REG_W, 5, register-index width
ZERO_REG, 31, index of XZR; never a forwarding source and never a hazard
PERF_W, 32, width of the optional performance counters

Ports:
clk  in  1  pipeline clock, rising-edge active
reset  in  1  asynchronous, active-low reset
dec_valid  in  1  decode slot holds a real instruction
dec_rs1  in  REG_W  first read register, instruction bits [9:5]
dec_rs2  in  REG_W  second read register, after the Reg2Loc selection
dec_use_rs1  in  1  instruction reads rs1
dec_use_rs2  in  1  instruction reads rs2; asserted for CBZ
dec_rd  in  REG_W  destination register
dec_regwrite  in  1  instruction writes dec_rd
dec_memread  in  1  instruction is a load
dec_setflags  in  1  instruction updates NZCV
dec_is_bcond  in  1  B.cond in decode; reads flags
dec_br_taken  in  1  accelerated branch resolved taken in decode
fw1_sel  out  2  select for the operand-1 forwarding mux
fw2_sel  out  2  select for the operand-2 forwarding mux
stall  out  1  hold PC and IF/ID this cycle
bubble_ex  out  1  load a NOP into ID/EX this cycle
flush_ifid  out  1  squash the instruction in IF/ID

Behaviour:
- Select encoding (package constants): FW_REG=2'b00, FW_MEM=2'b01, FW_ALU=2'b10. 2'b11 is never driven. WB-stage producers need no forwarding because the regfile writes on the falling edge.
- Shadow pipeline registers: ex_{v,rd,wr,ld,fl} and mem_{v,rd,wr}.
- Shadow update on each rising edge:
  - mem takes ex.
  - ex takes the decode fields gated by dec_valid & ~stall. A stalled instruction enters ex as a bubble (v=0).
- fwN_sel (combinational), for each used source s with s != ZERO_REG:
  - FW_ALU if ex_v & ex_wr & ~ex_ld & ex_rd==s.
  - Otherwise FW_MEM if mem_v & mem_wr & mem_rd==s.
  - Otherwise FW_REG.
  - The EX match has priority over the MEM match.
  - An unused source drives FW_REG.
- Hazards (combinational):
  - Load-use: ex_v & ex_ld & ex_wr, ex_rd != ZERO_REG, and ex_rd matches a used source.
  - Flag: dec_is_bcond & ex_v & ex_fl.
- FSM states: RUN and HOLD.
  - RUN: on hazard & dec_valid, assert stall and bubble_ex, then go to HOLD.
  - HOLD: the producer has advanced, so the re-evaluated hazard is false by construction. Return to RUN. If a new hazard is detected, stall again and stay in HOLD (this is a legal back-to-back case).
  - stall = bubble_ex = hazard & dec_valid in both states.
- flush_ifid = dec_valid & dec_br_taken & ~stall. When a stall and a taken branch occur in the same cycle, the stall wins and the branch is re-resolved next cycle.
- Reset (asynchronous, active-low):
  - All shadow v bits clear and the FSM goes to RUN.
  - Outputs: stall=0, bubble_ex=0, flush_ifid=0, fw1_sel=fw2_sel=FW_REG.
  - Reset asserted mid-stall abandons the stall immediately.
- Latency: every output is combinational from the current inputs and the shadow state. There is one-cycle state latency.

Optional Feature:
- Macro: HAZARD_FWD_PERF_CNT_EN.
- When defined:
  - Add outputs stall_cnt [PERF_W] and flush_cnt [PERF_W].
  - Each counter increments on cycles with stall and flush_ifid respectively.
  - Both saturate at all-ones and clear on reset.
- When undefined: the ports and logic are absent. Functional behaviour is otherwise identical.

Decomposition:
- Package hazard_fwd_pkg holds:
  - the FW_* select constants;
  - the FSM state enum (RUN, HOLD);
  - a packed shadow_slot_t struct {v, rd, wr, ld, fl}.
- Sub-module fwd_sel_unit is instantiated twice, once per operand. It takes a source, a use flag and the ex/mem slots, and returns a select.

Test Plan:
- ADD X1 then SUB X2,X1,X3 back-to-back -> fw1_sel=2'b10, no stall.
- ADD X1, an unrelated instruction, then ORR using X1 as rs2 -> fw2_sel=2'b01 in the third cycle.
- LDUR X4 then ADD X5,X4,X4 -> stall=bubble_ex=1 for one cycle, then fw1_sel=fw2_sel=2'b01 with stall=0.
- ADDS then B.LT immediately -> one stall cycle. Then with dec_br_taken=1: flush_ifid=1 in the next cycle only.
- Producer writes X31 followed by a reader of X31 -> fw sel=2'b00 and no stall. Also: EX and MEM both writing X7 -> EX wins (2'b10).
- Reset driven low while the FSM is in HOLD -> stall=0 and selects=2'b00 asynchronously. After release, the first instruction sees no stale forwards.
